// File: rtl/data_cache_ctrl_if.sv
// Bundle of request, flush, DDR burst and cache-array signals around data_cache_ctrl.
// slave is the controller side; master is the side that drives requests and DDR beats.
interface data_cache_ctrl_if #(
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH_MEM   = 16,
  parameter int DDR_ADDR_WIDTH   = 28
) ();
  localparam int IDX_W = $clog2(DATA_CACHE_DEPTH);

  logic                      req_valid;
  logic                      req_wr;
  logic [ADDR_WIDTH_MEM-1:0] req_addr;
  logic                      req_ready;
  logic                      req_done;
  logic [IDX_W-1:0]          cache_idx;
  logic                      flush_req;
  logic                      flush_done;
  logic [ADDR_WIDTH_MEM-1:0] tag_data;
  logic                      tag_valid;
  logic                      dirty;
  logic                      busy;
  logic                      ddr_rd_req;
  logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
  logic                      ddr_rd_valid;
  logic [DATA_WIDTH-1:0]     ddr_rd_data;
  logic                      cache_wr_en;
  logic [IDX_W-1:0]          cache_wr_addr;
  logic [DATA_WIDTH-1:0]     cache_wr_data;
  logic                      ddr_wr_req;
  logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr;
  logic                      ddr_wr_valid;
  logic                      ddr_wr_ready;
  logic [DATA_WIDTH-1:0]     ddr_wr_data;
  logic [IDX_W-1:0]          cache_rd_addr;
  logic [DATA_WIDTH-1:0]     cache_rd_data;

  modport slave (
    input  req_valid, req_wr, req_addr, flush_req,
    input  ddr_rd_valid, ddr_rd_data, ddr_wr_ready, cache_rd_data,
    output req_ready, req_done, cache_idx, flush_done,
    output tag_data, tag_valid, dirty, busy,
    output ddr_rd_req, ddr_rd_addr, cache_wr_en, cache_wr_addr, cache_wr_data,
    output ddr_wr_req, ddr_wr_addr, ddr_wr_valid, ddr_wr_data, cache_rd_addr
  );

  modport master (
    output req_valid, req_wr, req_addr, flush_req,
    output ddr_rd_valid, ddr_rd_data, ddr_wr_ready, cache_rd_data,
    input  req_ready, req_done, cache_idx, flush_done,
    input  tag_data, tag_valid, dirty, busy,
    input  ddr_rd_req, ddr_rd_addr, cache_wr_en, cache_wr_addr, cache_wr_data,
    input  ddr_wr_req, ddr_wr_addr, ddr_wr_valid, ddr_wr_data, cache_rd_addr
  );
endinterface

// File: rtl/data_cache_ctrl.sv
// Single-line data cache controller: hit/miss lookup, dirty writeback burst and
// refill burst to DDR, plus an explicit flush that writes back and invalidates.
module data_cache_ctrl #(
  parameter int DATA_CACHE_DEPTH = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH_MEM   = 16,
  parameter int DDR_ADDR_WIDTH   = 28
) (
  input logic               clk,
  input logic               rst,
  data_cache_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(DATA_CACHE_DEPTH);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(DATA_CACHE_DEPTH - 1);
  localparam logic [ADDR_WIDTH_MEM-1:0] LINE_MASK = ~ADDR_WIDTH_MEM'(DATA_CACHE_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA} state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH_MEM-1:0] req_addr_reg, req_addr_next;
  logic                      req_wr_reg, req_wr_next;
  logic [ADDR_WIDTH_MEM-1:0] new_tag_reg, new_tag_next;
  logic [ADDR_WIDTH_MEM-1:0] tag_data_reg, tag_data_next;
  logic                      tag_valid_reg, tag_valid_next;
  logic                      dirty_reg, dirty_next;
  logic [IDX_W-1:0]          wb_cnt_reg, wb_cnt_next;
  logic [IDX_W-1:0]          fill_cnt_reg, fill_cnt_next;
  logic                      flush_pending_reg, flush_pending_next;
  logic                      flush_done_reg, flush_done_next;
  logic                      req_ready_reg, req_ready_next;

  logic req_done, ddr_rd_req, ddr_wr_req, ddr_wr_valid, cache_wr_en, hit;
  logic [ADDR_WIDTH_MEM:0] addr_ext, tag_ext;

  // One extra bit so a line at the top of the address space cannot wrap into a false hit.
  assign addr_ext = {1'b0, req_addr_reg};
  assign tag_ext  = {1'b0, tag_data_reg};
  assign hit = tag_valid_reg && (addr_ext >= tag_ext) &&
               (addr_ext < tag_ext + (ADDR_WIDTH_MEM + 1)'(DATA_CACHE_DEPTH));

  always_comb begin
    state_next         = state_reg;
    req_addr_next      = req_addr_reg;
    req_wr_next        = req_wr_reg;
    new_tag_next       = new_tag_reg;
    tag_data_next      = tag_data_reg;
    tag_valid_next     = tag_valid_reg;
    dirty_next         = dirty_reg;
    wb_cnt_next        = wb_cnt_reg;
    fill_cnt_next      = fill_cnt_reg;
    flush_pending_next = flush_pending_reg;
    flush_done_next    = 1'b0;
    req_done           = 1'b0;
    ddr_rd_req         = 1'b0;
    ddr_wr_req         = 1'b0;
    ddr_wr_valid       = 1'b0;
    cache_wr_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_ready_reg) begin
          if (bus.flush_req) begin
            if (dirty_reg) begin
              flush_pending_next = 1'b1;
              state_next         = WB_REQ;
            end else begin
              tag_valid_next  = 1'b0;
              flush_done_next = 1'b1;
            end
          end else if (bus.req_valid) begin
            req_addr_next = bus.req_addr;
            req_wr_next   = bus.req_wr;
            state_next    = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (hit) begin
          req_done   = 1'b1;
          state_next = IDLE;
          if (req_wr_reg) dirty_next = 1'b1;
        end else begin
          new_tag_next       = req_addr_reg & LINE_MASK;
          flush_pending_next = 1'b0;
          state_next         = dirty_reg ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        ddr_wr_req  = 1'b1;
        wb_cnt_next = '0;
        state_next  = WB_DATA;
      end
      WB_DATA: begin
        ddr_wr_valid = 1'b1;
        if (bus.ddr_wr_ready) begin
          wb_cnt_next = wb_cnt_reg + 1'b1;
          if (wb_cnt_reg == LAST_BEAT) begin
            dirty_next = 1'b0;
            if (flush_pending_reg) begin
              tag_valid_next     = 1'b0;
              flush_done_next    = 1'b1;
              flush_pending_next = 1'b0;
              state_next         = IDLE;
            end else begin
              state_next = FILL_REQ;
            end
          end
        end
      end
      FILL_REQ: begin
        ddr_rd_req    = 1'b1;
        fill_cnt_next = '0;
        state_next    = FILL_DATA;
      end
      FILL_DATA: begin
        if (bus.ddr_rd_valid) begin
          cache_wr_en   = 1'b1;
          fill_cnt_next = fill_cnt_reg + 1'b1;
          // Back to LOOKUP rather than IDLE: the refilled line now holds the request.
          if (fill_cnt_reg == LAST_BEAT) begin
            tag_data_next  = new_tag_reg;
            tag_valid_next = 1'b1;
            dirty_next     = 1'b0;
            state_next     = LOOKUP;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    req_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      req_addr_reg      <= '0;
      req_wr_reg        <= 1'b0;
      new_tag_reg       <= '0;
      tag_data_reg      <= '0;
      tag_valid_reg     <= 1'b0;
      dirty_reg         <= 1'b0;
      wb_cnt_reg        <= '0;
      fill_cnt_reg      <= '0;
      flush_pending_reg <= 1'b0;
      flush_done_reg    <= 1'b0;
      req_ready_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      req_addr_reg      <= req_addr_next;
      req_wr_reg        <= req_wr_next;
      new_tag_reg       <= new_tag_next;
      tag_data_reg      <= tag_data_next;
      tag_valid_reg     <= tag_valid_next;
      dirty_reg         <= dirty_next;
      wb_cnt_reg        <= wb_cnt_next;
      fill_cnt_reg      <= fill_cnt_next;
      flush_pending_reg <= flush_pending_next;
      flush_done_reg    <= flush_done_next;
      req_ready_reg     <= req_ready_next;
    end
  end

  // Data outputs are gated so nothing from the DDR or cache inputs leaks out while idle or in reset.
  assign bus.req_ready     = req_ready_reg;
  assign bus.req_done      = req_done;
  assign bus.cache_idx     = IDX_W'(req_addr_reg - tag_data_reg);
  assign bus.flush_done    = flush_done_reg;
  assign bus.tag_data      = tag_data_reg;
  assign bus.tag_valid     = tag_valid_reg;
  assign bus.dirty         = dirty_reg;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.ddr_rd_req    = ddr_rd_req;
  assign bus.ddr_rd_addr   = DDR_ADDR_WIDTH'(new_tag_reg) << 3;
  assign bus.cache_wr_en   = cache_wr_en;
  assign bus.cache_wr_addr = fill_cnt_reg;
  assign bus.cache_wr_data = cache_wr_en ? bus.ddr_rd_data : ZERO_DATA;
  assign bus.ddr_wr_req    = ddr_wr_req;
  assign bus.ddr_wr_addr   = DDR_ADDR_WIDTH'(tag_data_reg) << 3;
  assign bus.ddr_wr_valid  = ddr_wr_valid;
  assign bus.ddr_wr_data   = ddr_wr_valid ? bus.cache_rd_data : ZERO_DATA;
  assign bus.cache_rd_addr = wb_cnt_reg;
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: cold miss, hit/boundary, dirty eviction,
// reset mid-fill, stray DDR beats and flush racing a request.
module tb_data_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  data_cache_ctrl_if bus_if ();

  data_cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Asynchronous-read cache array behind the controller.
  logic [15:0] cache_mem [16];
  always @(posedge clk) begin
    if (bus_if.cache_wr_en) cache_mem[bus_if.cache_wr_addr] <= bus_if.cache_wr_data;
  end
  assign bus_if.cache_rd_data = cache_mem[bus_if.cache_rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr);
    check("req_ready", 32'(bus_if.req_ready), 1);
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.req_wr    = 1'b0;
    #1;
    $display("txn %s addr=0x%04h", wr ? "store" : "load ", addr);
  endtask

  task automatic fill_line(input logic [15:0] base, input int beats, input int gap_at);
    for (int i = 0; i < beats; i++) begin
      if (i == gap_at) begin
        bus_if.ddr_rd_valid = 1'b0;
        #1;
        check("fill_gap_wr_en", 32'(bus_if.cache_wr_en), 0);
        tick();
      end
      bus_if.ddr_rd_valid = 1'b1;
      bus_if.ddr_rd_data  = base + 16'(i);
      #1;
      check("fill_wr_en", 32'(bus_if.cache_wr_en), 1);
      check("fill_wr_addr", 32'(bus_if.cache_wr_addr), 32'(i));
      check("fill_wr_data", 32'(bus_if.cache_wr_data), 32'(base + 16'(i)));
      tick();
    end
    bus_if.ddr_rd_valid = 1'b0;
    #1;
    $display("txn fill base=0x%04h beats=%0d", base, beats);
  endtask

  // Write-back with ddr_wr_ready toggling; data must hold until a beat is accepted.
  task automatic wb_line(input logic [15:0] base);
    int k = 0;
    for (int cyc = 0; cyc < 64 && k < 16; cyc++) begin
      bus_if.ddr_wr_ready = cyc[0];
      #1;
      check("wb_valid", 32'(bus_if.ddr_wr_valid), 1);
      check("wb_data", 32'(bus_if.ddr_wr_data), 32'(base + 16'(k)));
      if (bus_if.ddr_wr_ready) k++;
      tick();
    end
    bus_if.ddr_wr_ready = 1'b0;
    check("wb_beats", 32'(k), 16);
    $display("txn writeback base=0x%04h beats=%0d", base, k);
  endtask

  initial begin
    bus_if.req_valid    = 1'b0;
    bus_if.req_wr       = 1'b0;
    bus_if.req_addr     = '0;
    bus_if.flush_req    = 1'b0;
    bus_if.ddr_rd_valid = 1'b0;
    bus_if.ddr_rd_data  = '0;
    bus_if.ddr_wr_ready = 1'b0;

    // Reset state
    #2;
    check("rst_req_ready", 32'(bus_if.req_ready), 0);
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_tag_valid", 32'(bus_if.tag_valid), 0);
    check("rst_tag_data", 32'(bus_if.tag_data), 0);
    check("rst_dirty", 32'(bus_if.dirty), 0);
    check("rst_ddr_rd_req", 32'(bus_if.ddr_rd_req), 0);
    check("rst_flush_done", 32'(bus_if.flush_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("ready_after_rst", 32'(bus_if.req_ready), 1);

    // Cold miss: load 0x0025
    issue(1'b0, 16'h0025);
    check("cold_lookup_done", 32'(bus_if.req_done), 0);
    check("cold_busy", 32'(bus_if.busy), 1);
    tick();
    check("cold_rd_req", 32'(bus_if.ddr_rd_req), 1);
    check("cold_rd_addr", 32'(bus_if.ddr_rd_addr), 32'h100);
    tick();
    check("cold_rd_req_pulse", 32'(bus_if.ddr_rd_req), 0);
    fill_line(16'hA000, 16, 8);
    check("cold_done", 32'(bus_if.req_done), 1);
    check("cold_idx", 32'(bus_if.cache_idx), 5);
    check("cold_tag", 32'(bus_if.tag_data), 32'h20);
    check("cold_tag_valid", 32'(bus_if.tag_valid), 1);
    tick();
    check("cold_done_pulse", 32'(bus_if.req_done), 0);
    check("cold_idle", 32'(bus_if.busy), 0);

    // Hit at the top of the line
    issue(1'b0, 16'h002F);
    check("hit_done", 32'(bus_if.req_done), 1);
    check("hit_idx", 32'(bus_if.cache_idx), 15);
    check("hit_no_ddr", 32'(bus_if.ddr_rd_req), 0);
    tick();
    check("hit_idle", 32'(bus_if.busy), 0);

    // Store hit marks the line dirty
    issue(1'b1, 16'h0021);
    check("store_done", 32'(bus_if.req_done), 1);
    check("store_idx", 32'(bus_if.cache_idx), 1);
    tick();
    check("store_dirty", 32'(bus_if.dirty), 1);

    // Dirty eviction: load 0x0040
    issue(1'b0, 16'h0040);
    check("evict_miss", 32'(bus_if.req_done), 0);
    tick();
    check("evict_wr_req", 32'(bus_if.ddr_wr_req), 1);
    check("evict_wr_addr", 32'(bus_if.ddr_wr_addr), 32'h100);
    tick();
    wb_line(16'hA000);
    check("evict_rd_req", 32'(bus_if.ddr_rd_req), 1);
    check("evict_rd_addr", 32'(bus_if.ddr_rd_addr), 32'h200);
    check("evict_clean", 32'(bus_if.dirty), 0);
    check("evict_wr_valid_off", 32'(bus_if.ddr_wr_valid), 0);
    tick();
    fill_line(16'hB000, 16, -1);
    check("evict_done", 32'(bus_if.req_done), 1);
    check("evict_idx", 32'(bus_if.cache_idx), 0);
    check("evict_tag", 32'(bus_if.tag_data), 32'h40);
    tick();

    // Boundary miss 0x0030, then reset at fill beat 7
    issue(1'b0, 16'h0030);
    check("bnd_miss", 32'(bus_if.req_done), 0);
    tick();
    check("bnd_rd_req", 32'(bus_if.ddr_rd_req), 1);
    check("bnd_rd_addr", 32'(bus_if.ddr_rd_addr), 32'h180);
    tick();
    fill_line(16'hC000, 7, -1);
    bus_if.ddr_rd_valid = 1'b1;
    bus_if.ddr_rd_data  = 16'hC007;
    #1;
    check("beat7_wr_en", 32'(bus_if.cache_wr_en), 1);
    check("beat7_wr_addr", 32'(bus_if.cache_wr_addr), 7);
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(bus_if.cache_wr_en), 0);
    check("mid_rst_wr_addr", 32'(bus_if.cache_wr_addr), 0);
    check("mid_rst_busy", 32'(bus_if.busy), 0);
    check("mid_rst_tag_valid", 32'(bus_if.tag_valid), 0);
    check("mid_rst_tag_data", 32'(bus_if.tag_data), 0);
    check("mid_rst_rd_addr", 32'(bus_if.ddr_rd_addr), 0);
    check("mid_rst_wr_data", 32'(bus_if.cache_wr_data), 0);
    check("mid_rst_req_ready", 32'(bus_if.req_ready), 0);
    tick();
    check("stray_in_rst", 32'(bus_if.cache_wr_en), 0);
    rst = 1'b1;
    tick();
    check("stray_after_rst", 32'(bus_if.cache_wr_en), 0);
    check("stray_busy", 32'(bus_if.busy), 0);
    bus_if.ddr_rd_valid = 1'b0;
    $display("txn reset during fill");

    // The next load misses again
    issue(1'b0, 16'h0030);
    check("post_rst_miss", 32'(bus_if.req_done), 0);
    tick();
    check("post_rst_rd_req", 32'(bus_if.ddr_rd_req), 1);
    check("post_rst_rd_addr", 32'(bus_if.ddr_rd_addr), 32'h180);
    tick();
    fill_line(16'hC000, 16, -1);
    check("post_rst_done", 32'(bus_if.req_done), 1);
    check("post_rst_tag", 32'(bus_if.tag_data), 32'h30);
    tick();

    // Stray read beats while idle
    for (int i = 0; i < 3; i++) begin
      bus_if.ddr_rd_valid = 1'b1;
      #1;
      check("idle_stray_wr_en", 32'(bus_if.cache_wr_en), 0);
      check("idle_stray_busy", 32'(bus_if.busy), 0);
      tick();
    end
    bus_if.ddr_rd_valid = 1'b0;
    check("idle_stray_ready", 32'(bus_if.req_ready), 1);
    check("idle_stray_tag", 32'(bus_if.tag_data), 32'h30);
    $display("txn stray beats in idle");

    // Dirty line, then flush and load arriving together
    issue(1'b1, 16'h0035);
    check("st35_done", 32'(bus_if.req_done), 1);
    check("st35_idx", 32'(bus_if.cache_idx), 5);
    tick();
    check("st35_dirty", 32'(bus_if.dirty), 1);
    bus_if.flush_req = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 16'h0035;
    tick();
    bus_if.flush_req = 1'b0;
    check("flush_wr_req", 32'(bus_if.ddr_wr_req), 1);
    check("flush_wr_addr", 32'(bus_if.ddr_wr_addr), 32'h180);
    check("flush_not_ready", 32'(bus_if.req_ready), 0);
    tick();
    wb_line(16'hC000);
    check("flush_done", 32'(bus_if.flush_done), 1);
    check("flush_invalid", 32'(bus_if.tag_valid), 0);
    check("flush_clean", 32'(bus_if.dirty), 0);
    check("flush_idle_ready", 32'(bus_if.req_ready), 1);
    tick();
    bus_if.req_valid = 1'b0;
    #1;
    $display("txn flush+load addr=0x0035");
    check("flush_done_pulse", 32'(bus_if.flush_done), 0);
    check("after_flush_miss", 32'(bus_if.req_done), 0);
    check("after_flush_busy", 32'(bus_if.busy), 1);
    tick();
    check("after_flush_rd_req", 32'(bus_if.ddr_rd_req), 1);
    check("after_flush_rd_addr", 32'(bus_if.ddr_rd_addr), 32'h180);
    tick();
    fill_line(16'hD000, 16, -1);
    check("after_flush_done", 32'(bus_if.req_done), 1);
    check("after_flush_idx", 32'(bus_if.cache_idx), 5);
    tick();

    // Flush of a clean line completes without DDR traffic
    bus_if.flush_req = 1'b1;
    tick();
    bus_if.flush_req = 1'b0;
    #1;
    $display("txn clean flush");
    check("clean_flush_done", 32'(bus_if.flush_done), 1);
    check("clean_flush_invalid", 32'(bus_if.tag_valid), 0);
    check("clean_flush_busy", 32'(bus_if.busy), 0);
    tick();
    check("clean_flush_pulse", 32'(bus_if.flush_done), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 The parameters SHALL be (name, default, meaning):
- DATA_CACHE_DEPTH, 16, words per line; power of two.
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH_MEM, 16, word address width.
- DDR_ADDR_WIDTH, 28, DDR address width.
REQ-002 clk  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  access request; req_wr in 1 (1=store, 0=load); req_addr in ADDR_WIDTH_MEM.
REQ-005 req_ready  out  1  high only in IDLE; req_done out 1 one-cycle completion pulse; cache_idx out log2(DEPTH) line index, valid with req_done.
REQ-006 flush_req  in  1  write back and invalidate the line; flush_done out 1 one-cycle pulse.
REQ-007 tag_data  out  ADDR_WIDTH_MEM  base of the resident line; tag_valid out 1; dirty out 1; busy out 1 (state != IDLE).
REQ-008 ddr_rd_req  out  1  one-cycle burst-read request; ddr_rd_addr out DDR_ADDR_WIDTH; ddr_rd_valid in 1 beat strobe; ddr_rd_data in DATA_WIDTH.
REQ-009 cache_wr_en  out  1; cache_wr_addr out log2(DEPTH); cache_wr_data out DATA_WIDTH (fill port).
REQ-010 ddr_wr_req  out  1  one-cycle burst-write request; ddr_wr_addr out DDR_ADDR_WIDTH; ddr_wr_valid out 1; ddr_wr_ready in 1; ddr_wr_data out DATA_WIDTH.
REQ-011 cache_rd_addr  out  log2(DEPTH); cache_rd_data in DATA_WIDTH (asynchronous-read cache array).

Function
REQ-012 States SHALL be IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA.
REQ-013 IDLE: flush_req has priority over req_valid; flush with dirty=1 -> WB_REQ; flush with dirty=0 -> tag_valid<=0, flush_done pulse next cycle, stay IDLE; req_valid -> latch req_addr/req_wr, -> LOOKUP.
REQ-014 Hit SHALL be tag_valid && req_addr >= tag_data && req_addr < tag_data+DEPTH, compared at ADDR_WIDTH_MEM+1 bits (no wrap).
REQ-015 LOOKUP hit: req_done=1, cache_idx=req_addr-tag_data (low bits); a store sets dirty<=1; -> IDLE. Hit latency: 1 cycle after acceptance.
REQ-016 LOOKUP miss: new_tag = req_addr with the low log2(DEPTH) bits cleared; dirty -> WB_REQ, else -> FILL_REQ.
REQ-017 WB_REQ: ddr_wr_req=1 for one cycle, ddr_wr_addr = tag_data<<3 zero-extended; -> WB_DATA with wb_cnt=0.
REQ-018 WB_DATA: cache_rd_addr=wb_cnt, ddr_wr_valid=1, ddr_wr_data=cache_rd_data; wb_cnt advances only on valid&&ready; data held while ready=0.
REQ-019 After beat DEPTH-1 is accepted: dirty<=0; flush -> tag_valid<=0, flush_done pulse, -> IDLE; miss -> FILL_REQ.
REQ-020 FILL_REQ: ddr_rd_req=1 for one cycle, ddr_rd_addr = new_tag<<3; -> FILL_DATA with fill_cnt=0.
REQ-021 FILL_DATA: each ddr_rd_valid cycle asserts cache_wr_en with cache_wr_addr=fill_cnt and cache_wr_data=ddr_rd_data, then fill_cnt+1. On beat DEPTH-1: tag_data<=new_tag, tag_valid<=1, dirty<=0, -> LOOKUP (guaranteed hit).
REQ-022 ddr_rd_valid outside FILL_DATA and ddr_wr_ready outside WB_DATA SHALL be ignored; requests arriving while busy are not accepted (req_ready=0).

Reset
REQ-023 rst low SHALL immediately force IDLE and clear every output, counter, tag_data, tag_valid and dirty to 0; an in-flight burst is abandoned and its late beats are ignored under REQ-022.

Verification
REQ-024 Cold miss: after reset, load 0x0025 -> ddr_rd_req with ddr_rd_addr=0x100; 16 beats drive cache_wr_addr 0..15; tag_data=0x0020; req_done with cache_idx=5 one cycle after the last beat.
REQ-025 Hit and boundary: load 0x002F -> req_done one cycle after acceptance, cache_idx=15, no DDR traffic; load 0x0030 -> miss, ddr_rd_addr=0x180.
REQ-026 Dirty eviction: store 0x0021 (hit, dirty=1), then load 0x0040 -> ddr_wr_addr=0x100; 16 write beats with ddr_wr_ready toggled every cycle hold data stable; then ddr_rd_addr=0x200; dirty=0.
REQ-027 Reset at fill beat 7 -> all outputs 0, tag_valid=0; stray ddr_rd_valid produces no cache_wr_en; the next load misses.
REQ-028 Simultaneous flush_req and req_valid with dirty=1 -> writeback of 16 beats, tag_valid=0, flush_done pulse; the request is then accepted and misses.
REQ-029 ddr_rd_valid pulses while in IDLE -> no cache_wr_en and no state change.
